// File: rtl/alu_uart_frame_ctrl.sv
// UART <-> ALU framing stage.
// Assembles NB-byte operands A and B plus an opcode byte from the receive
// stream, commits them to the ALU in one edge, captures the result and
// sends it back LSB first using the tx_start / tx_done_tick handshake.
// A partial frame that goes idle for TIMEOUT_CYCLES clocks is discarded.
module alu_uart_frame_ctrl #(
  parameter int unsigned LEN_UART       = 8,
  parameter int unsigned LEN_DATA       = 16,
  parameter int unsigned LEN_OPCODE     = 6,
  parameter int unsigned ALU_LATENCY    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [LEN_UART-1:0]   rx_data_in,
  input  logic                  tx_done_tick,
  input  logic [LEN_DATA-1:0]   alu_data_in,
  output logic                  tx_start,
  output logic [LEN_UART-1:0]   tx_data_out,
  output logic [LEN_DATA-1:0]   A,
  output logic [LEN_DATA-1:0]   B,
  output logic [LEN_OPCODE-1:0] OPCODE,
  output logic                  busy,
  output logic                  frame_error
);

  localparam int unsigned NB       = LEN_DATA / LEN_UART;
  localparam int unsigned IDX_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned LAT_W    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam int unsigned LAT_LAST = (ALU_LATENCY > 0) ? ALU_LATENCY - 1 : 0;
  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    RX_A    = 3'd0,
    RX_B    = 3'd1,
    RX_OP   = 3'd2,
    CALC    = 3'd3,
    TX_LOAD = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [LAT_W-1:0]      lat_cnt, lat_cnt_nxt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic [LEN_DATA-1:0]   shadow_a, shadow_a_nxt;
  logic [LEN_DATA-1:0]   shadow_b, shadow_b_nxt;
  logic [LEN_DATA-1:0]   result, result_nxt;
  logic [LEN_DATA-1:0]   a_nxt, b_nxt;
  logic [LEN_OPCODE-1:0] opcode_nxt;
  logic [LEN_UART-1:0]   tx_data_nxt;
  logic                  tx_start_nxt;
  logic                  busy_nxt;
  logic                  frame_error_nxt;
  logic                  partial_c;
  logic                  last_byte_c;

  assign last_byte_c = (idx == IDX_W'(NB - 1));

  // A frame is in flight once its first byte has landed and until the commit.
  assign partial_c = ((state == RX_A) && (idx != '0)) || (state == RX_B) || (state == RX_OP);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RX_A;
      idx         <= '0;
      lat_cnt     <= '0;
      tmo_cnt     <= '0;
      shadow_a    <= '0;
      shadow_b    <= '0;
      result      <= '0;
      A           <= '0;
      B           <= '0;
      OPCODE      <= '0;
      tx_data_out <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      lat_cnt     <= lat_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      shadow_a    <= shadow_a_nxt;
      shadow_b    <= shadow_b_nxt;
      result      <= result_nxt;
      A           <= a_nxt;
      B           <= b_nxt;
      OPCODE      <= opcode_nxt;
      tx_data_out <= tx_data_nxt;
      tx_start    <= tx_start_nxt;
      busy        <= busy_nxt;
      frame_error <= frame_error_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    lat_cnt_nxt     = lat_cnt;
    tmo_cnt_nxt     = '0;
    shadow_a_nxt    = shadow_a;
    shadow_b_nxt    = shadow_b;
    result_nxt      = result;
    a_nxt           = A;
    b_nxt           = B;
    opcode_nxt      = OPCODE;
    tx_data_nxt     = tx_data_out;
    tx_start_nxt    = 1'b0;
    frame_error_nxt = 1'b0;

    case (state)
      RX_A: begin
        if (rx_done_tick) begin
          shadow_a_nxt[idx*LEN_UART +: LEN_UART] = rx_data_in;
          if (last_byte_c) begin
            idx_nxt   = '0;
            state_nxt = RX_B;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      RX_B: begin
        if (rx_done_tick) begin
          shadow_b_nxt[idx*LEN_UART +: LEN_UART] = rx_data_in;
          if (last_byte_c) begin
            idx_nxt   = '0;
            state_nxt = RX_OP;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      RX_OP: begin
        // Operands and opcode become visible to the ALU on the same edge.
        if (rx_done_tick) begin
          a_nxt       = shadow_a;
          b_nxt       = shadow_b;
          opcode_nxt  = rx_data_in[LEN_OPCODE-1:0];
          lat_cnt_nxt = '0;
          state_nxt   = CALC;
        end
      end
      CALC: begin
        if (lat_cnt == LAT_W'(LAT_LAST)) begin
          result_nxt = alu_data_in;
          idx_nxt    = '0;
          state_nxt  = TX_LOAD;
        end else begin
          lat_cnt_nxt = lat_cnt + LAT_W'(1);
        end
      end
      TX_LOAD: begin
        tx_data_nxt  = result[idx*LEN_UART +: LEN_UART];
        tx_start_nxt = 1'b1;
        state_nxt    = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done_tick) begin
          if (last_byte_c) begin
            idx_nxt   = '0;
            state_nxt = RX_A;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = TX_LOAD;
          end
        end
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = RX_A;
      end
    endcase

    // Inter-byte timeout; a byte arriving on the expiry cycle wins.
    if ((TIMEOUT_CYCLES != 0) && partial_c && !rx_done_tick) begin
      if (tmo_cnt == TMO_W'(TMO_LAST)) begin
        frame_error_nxt = 1'b1;
        state_nxt       = RX_A;
        idx_nxt         = '0;
      end else begin
        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
      end
    end

    busy_nxt = !((state_nxt == RX_A) && (idx_nxt == '0));
  end

endmodule

// File: tb/tb_alu_uart_frame_ctrl.sv
// Directed bench for alu_uart_frame_ctrl: a 16-bit instance with a short
// timeout and an 8-bit (single-byte) instance, each with an A+B ALU stub.
module tb_alu_uart_frame_ctrl;

  logic        clk;
  logic        reset;

  // 16-bit instance
  logic        rx_done_tick;
  logic [7:0]  rx_data_in;
  logic        tx_done_tick;
  logic [15:0] alu_data_in;
  logic        tx_start;
  logic [7:0]  tx_data_out;
  logic [15:0] a;
  logic [15:0] b;
  logic [5:0]  opcode;
  logic        busy;
  logic        frame_error;

  // 8-bit instance
  logic        rx8_done_tick;
  logic [7:0]  rx8_data_in;
  logic        tx8_done_tick;
  logic [7:0]  alu8_data_in;
  logic        tx8_start;
  logic [7:0]  tx8_data_out;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [5:0]  opcode8;
  logic        busy8;
  logic        frame_error8;

  int tests;
  int fails;

  alu_uart_frame_ctrl #(
    .LEN_UART(8), .LEN_DATA(16), .LEN_OPCODE(6), .ALU_LATENCY(1), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_done_tick(rx_done_tick), .rx_data_in(rx_data_in),
    .tx_done_tick(tx_done_tick), .alu_data_in(alu_data_in),
    .tx_start(tx_start), .tx_data_out(tx_data_out),
    .A(a), .B(b), .OPCODE(opcode),
    .busy(busy), .frame_error(frame_error)
  );

  alu_uart_frame_ctrl #(
    .LEN_UART(8), .LEN_DATA(8), .LEN_OPCODE(6), .ALU_LATENCY(1), .TIMEOUT_CYCLES(0)
  ) dut8 (
    .clk(clk), .reset(reset),
    .rx_done_tick(rx8_done_tick), .rx_data_in(rx8_data_in),
    .tx_done_tick(tx8_done_tick), .alu_data_in(alu8_data_in),
    .tx_start(tx8_start), .tx_data_out(tx8_data_out),
    .A(a8), .B(b8), .OPCODE(opcode8),
    .busy(busy8), .frame_error(frame_error8)
  );

  // ALU stubs: combinational sum, valid one cycle after commit.
  assign alu_data_in  = a + b;
  assign alu8_data_in = a8 + b8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    rx_data_in   = v;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic send_byte8(input logic [7:0] v);
    rx8_data_in   = v;
    rx8_done_tick = 1'b1;
    step();
    rx8_done_tick = 1'b0;
  endtask

  // Wait (bounded) until tx_start is high at the current sample point.
  task automatic wait_start(output logic got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_start) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Accept one transmitted byte, check it, then answer with tx_done_tick.
  task automatic serve_tx(input string tag, input logic [7:0] exp);
    logic got;
    wait_start(got);
    chk({tag, "_start"}, 32'(got), 32'h1);
    chk({tag, "_data"}, 32'(tx_data_out), 32'(exp));
    step();
    chk({tag, "_pulse"}, 32'(tx_start), 32'h0);
    step();
    step();
    chk({tag, "_stable"}, 32'(tx_data_out), 32'(exp));
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  initial begin
    logic got;
    logic fe_seen;
    int   n;
    int   starts;

    tests         = 0;
    fails         = 0;
    reset         = 1'b0;
    rx_done_tick  = 1'b0;
    rx_data_in    = 8'h00;
    tx_done_tick  = 1'b0;
    rx8_done_tick = 1'b0;
    rx8_data_in   = 8'h00;
    tx8_done_tick = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_b", 32'(b), 32'h0);
    chk("rst_op", 32'(opcode), 32'h0);
    chk("rst_txd", 32'(tx_data_out), 32'h0);
    chk("rst_txs", 32'(tx_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ferr", 32'(frame_error), 32'h0);
    reset = 1'b1;
    step();

    // Basic frame: A=0x1234, B=0x0001, opcode byte E0 -> 0x20
    send_byte(8'h34);
    chk("f1_busy_first", 32'(busy), 32'h1);
    send_byte(8'h12);
    send_byte(8'h01);
    send_byte(8'h00);
    chk("f1_a_midframe", 32'(a), 32'h0);
    send_byte(8'hE0);
    chk("f1_a", 32'(a), 32'h1234);
    chk("f1_b", 32'(b), 32'h0001);
    chk("f1_op", 32'(opcode), 32'h20);
    serve_tx("f1_b0", 8'h35);
    chk("f1_busy_mid", 32'(busy), 32'h1);
    serve_tx("f1_b1", 8'h12);
    chk("f1_busy_end", 32'(busy), 32'h0);

    // Timeout: partial frame goes idle, error pulse 50 cycles after last byte
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h01);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (frame_error) begin
        n = i;
        break;
      end
    end
    chk("to_cycle", 32'(n), 32'd50);
    step();
    chk("to_pulse", 32'(frame_error), 32'h0);
    chk("to_busy", 32'(busy), 32'h0);
    chk("to_a_kept", 32'(a), 32'h1234);
    chk("to_b_kept", 32'(b), 32'h0001);
    chk("to_op_kept", 32'(opcode), 32'h20);
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("to_fresh_a", 32'(a), 32'h00AA);
    chk("to_fresh_b", 32'(b), 32'h0001);
    chk("to_fresh_op", 32'(opcode), 32'h00);
    serve_tx("to_b0", 8'hAB);
    serve_tx("to_b1", 8'h00);

    // Bytes arriving during TX_WAIT are dropped
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h05);
    wait_start(got);
    chk("drop_start", 32'(got), 32'h1);
    chk("drop_data0", 32'(tx_data_out), 32'h03);
    step();
    send_byte(8'h55);
    send_byte(8'h66);
    chk("drop_a", 32'(a), 32'h0001);
    chk("drop_txd", 32'(tx_data_out), 32'h03);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    serve_tx("drop_b1", 8'h00);
    chk("drop_busy", 32'(busy), 32'h0);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h03);
    chk("drop_next_a", 32'(a), 32'h0010);
    chk("drop_next_b", 32'(b), 32'h0020);
    chk("drop_next_op", 32'(opcode), 32'h03);
    serve_tx("drop_n0", 8'h30);
    serve_tx("drop_n1", 8'h00);

    // Asynchronous reset during TX_WAIT
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_start(got);
    chk("ar_start", 32'(got), 32'h1);
    chk("ar_data", 32'(tx_data_out), 32'h05);
    step();
    reset = 1'b0;
    #1;
    chk("ar_a", 32'(a), 32'h0);
    chk("ar_b", 32'(b), 32'h0);
    chk("ar_op", 32'(opcode), 32'h0);
    chk("ar_txd", 32'(tx_data_out), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    step();
    reset = 1'b1;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_start) starts++;
    end
    chk("ar_no_restart", 32'(starts), 32'd0);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h02);
    chk("ar_new_a", 32'(a), 32'h0004);
    serve_tx("ar_n0", 8'h09);
    serve_tx("ar_n1", 8'h00);

    // Byte on the expiry cycle is accepted
    send_byte(8'h34);
    fe_seen = 1'b0;
    for (int i = 0; i < 49; i++) begin
      step();
      fe_seen = fe_seen | frame_error;
    end
    send_byte(8'h12);
    fe_seen = fe_seen | frame_error;
    step();
    fe_seen = fe_seen | frame_error;
    chk("tie_no_ferr", 32'(fe_seen), 32'h0);
    chk("tie_busy", 32'(busy), 32'h1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hE0);
    chk("tie_a", 32'(a), 32'h1234);
    chk("tie_b", 32'(b), 32'h0001);
    serve_tx("tie_b0", 8'h35);
    serve_tx("tie_b1", 8'h12);

    // Single-byte words
    send_byte8(8'h07);
    send_byte8(8'h03);
    send_byte8(8'h01);
    chk("nb1_a", 32'(a8), 32'h07);
    chk("nb1_b", 32'(b8), 32'h03);
    chk("nb1_op", 32'(opcode8), 32'h01);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx8_start) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("nb1_start", 32'(got), 32'h1);
    chk("nb1_data", 32'(tx8_data_out), 32'h0A);
    step();
    step();
    tx8_done_tick = 1'b1;
    step();
    tx8_done_tick = 1'b0;
    chk("nb1_busy", 32'(busy8), 32'h0);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx8_start) starts++;
    end
    chk("nb1_one_start", 32'(starts), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_uart_frame_ctrl.md
Name: alu_uart_frame_ctrl

Overview:
- Parametrised successor of the UART-to-ALU interface stage. Sits between uart_rx/uart_tx and the ALU.
- Assembles multi-byte operands A and B plus an opcode byte from the UART receive stream, then commits them atomically to the ALU.
- Captures the ALU result and serialises it back as multiple bytes using a tx_start/tx_done handshake.
- Adds an inter-byte timeout that discards partial frames.

Parameters:
- LEN_UART, 8, UART byte width.
- LEN_DATA, 16, operand and result width. Must be an integer multiple of LEN_UART. NB = LEN_DATA/LEN_UART bytes per word.
- LEN_OPCODE, 6, opcode width. Must be ≤ LEN_UART.
- ALU_LATENCY, 1, cycles from commit to a valid alu_data_in. Minimum 1.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes of one frame. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_done_tick  in  1  one-cycle pulse: rx_data_in is valid.
- rx_data_in  in  LEN_UART  received byte.
- tx_done_tick  in  1  one-cycle pulse from uart_tx: byte fully sent.
- alu_data_in  in  LEN_DATA  ALU result.
- tx_start  out  1  one-cycle pulse: send tx_data_out.
- tx_data_out  out  LEN_UART  byte to transmit. Registered; stable from tx_start until tx_done_tick.
- A  out  LEN_DATA  committed operand A.
- B  out  LEN_DATA  committed operand B.
- OPCODE  out  LEN_OPCODE  committed opcode.
- busy  out  1  high in every state except RX_A with byte index 0.
- frame_error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RX_A, byte index=0, timeout counter=0.
  - A, B, OPCODE, tx_data_out, shadow registers and result register = 0.
  - tx_start=0, frame_error=0, busy=0.
- Frame format: NB bytes of A, least-significant byte first; then NB bytes of B, LSB first; then 1 opcode byte. OPCODE takes rx_data_in[LEN_OPCODE-1:0]; upper bits are ignored.
- RX_A / RX_B:
  - Each rx_done_tick writes the byte into the shadow A or B at slice [idx*LEN_UART +: LEN_UART] and increments idx.
  - On the NB-th byte: idx=0 and advance RX_A→RX_B→RX_OP.
- RX_OP: on rx_done_tick, in the same edge, A<=shadowA, B<=shadowB, OPCODE<=byte (atomic commit), then go to CALC. A, B and OPCODE never change mid-frame.
- CALC: count ALU_LATENCY cycles after commit, capture alu_data_in into the result register, set tx idx=0, go to TX_LOAD.
- TX_LOAD: tx_data_out<=result byte[idx], tx_start=1 for exactly one cycle, go to TX_WAIT.
- TX_WAIT:
  - On tx_done_tick: if idx==NB-1, go to RX_A (busy drops the following cycle); otherwise idx++ and go to TX_LOAD.
  - Minimum spacing between tx_start pulses is the tx_done_tick plus 1 cycle.
- rx_done_tick during CALC/TX_LOAD/TX_WAIT: byte dropped, no state change, no error.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter runs only while a frame is partially received (RX_A with idx>0, RX_B, RX_OP). It clears on every rx_done_tick and on every state entry to RX_A with idx 0.
  - When the counter reaches TIMEOUT_CYCLES: frame_error=1 for 1 cycle, state=RX_A, idx=0, shadows kept but unused. A, B and OPCODE keep their previous committed values.
  - If rx_done_tick and expiry land in the same cycle, the byte wins: it is accepted and the counter clears.
- Reset mid-operation (any state): immediate return to reset values. An in-flight tx_start is not reissued.
- Result bytes are taken from the registered capture only. Changes on alu_data_in after capture have no effect.

Test Plan:
- LEN_DATA=16, ALU stub = A+B with 1-cycle latency. Send 34,12,01,00,E0 → A=0x1234, B=0x0001, OPCODE=0x20 committed on the 5th tick. tx_start pulses with tx_data_out=0x35, then after tx_done_tick 0x12. busy drops after the second tx_done_tick.
- Send 34,12,01, then idle TIMEOUT_CYCLES (set to 50) → frame_error pulse at cycle 50, A/B/OPCODE unchanged. The next bytes AA,00,01,00,00 form a fresh frame → A=0x00AA, B=0x0001.
- Bytes 55,66 sent during TX_WAIT → ignored. The transmitted result is unchanged, and the following frame is decoded from byte 0.
- Assert reset low during TX_WAIT of the first result byte → all outputs 0 within the same cycle (asynchronous). No further tx_start. A new frame is processed normally afterwards.
- rx_done_tick in the same cycle as timeout expiry → byte accepted, no frame_error.
- LEN_DATA=8 (NB=1): bytes 07,03,01 → A=7, B=3, OPCODE=1. Exactly one tx_start.
